simple_pipe_issue_q: RTL
========================

# simple_pipe_issue_q

Instruction issue front-end for the 4-register add/sub/and pipeline. Buffers 8-bit instructions pushed by a host over a valid/ready handshake and drives the pipeline's `inst` and start inputs, issuing one instruction per enabled cycle. Inserts NOPs when the queue is empty. Can optionally insert NOP bubbles to resolve RAW hazards for pipeline variants without forwarding.

## Interface
- `DEPTH`, 4: number of queue entries; must be a power of 2 and ≥2.
- `CNT_W`, 16: width of the statistics counters.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: host offers `in_inst`.
- `in_ready` out 1: queue can accept; equals !full.
- `in_inst` in 8: {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}.
- `issue_en` in 1: global advance enable.
- `out_inst` out 8: instruction presented to pipeline ID.
- `out_start` out 1: pipeline start; combinational copy of `issue_en`.
- `q_count` out $clog2(DEPTH)+1: current occupancy.
- `stall` out 1: head held this cycle because of a hazard; 0 when the feature is compiled out.
- `issued_cnt` out CNT_W: count of non-bubble instructions issued.
- `bubble_cnt` out CNT_W: count of hazard bubbles issued.

## Operation
- Push on an edge where `in_valid && in_ready`. There is no bypass: a pushed entry is visible at the head on the next cycle.
- Advance edge is any edge with `issue_en=1`. On each advance edge, `out_inst` loads one of:
  - the popped head, if the queue is non-empty and `stall=0`;
  - otherwise `8'h00` (NOP).
- With `issue_en=0`, `out_inst`, the queue head, the history and both counters hold. Pushes are still accepted.
- Push and pop may happen on the same edge; `q_count` is unchanged in that case.
- When full, `in_ready=0` even if a pop occurs that cycle. The host retries next cycle.
- A wen-class op is ADD, SUB or AND (op≠00). All wen ops read both rs1 and rs2.
- `issued_cnt` increments when a popped instruction is loaded, including a queued NOP. It wraps modulo 2^CNT_W.
- `bubble_cnt` increments when a NOP is loaded because `stall=1`. Empty-queue NOPs are not counted. It wraps.
- Reset (including mid-operation):
  - queue flushed; `q_count=0`, `in_ready=1`;
  - `out_inst=8'h00`, `stall=0`;
  - both counters 0; hazard history cleared (wen=0).

## Timing
- Latency: an instruction pushed at edge t appears on `out_inst` at the earliest after edge t+1, given `issue_en=1` and no stall.
- Throughput: one instruction per advance edge.
- `out_inst` is registered. All status outputs are registered except `out_start` and `stall`, which are combinational from the head, the history and `issue_en`.
- Hazard window: a result becomes readable by an instruction whose ID cycle is at least 3 advances after the writer's ID cycle. The block therefore tracks the two most recently issued slots: h0 is the current `out_inst`, h1 is the slot before it.

## Configuration
- `SIMPLE_PIPE_HAZARD_STALL_EN` defined:
  - history h0/h1 holds {rd, wen} and shifts on every advance edge; bubbles count as wen=0 slots.
  - `stall = q_count≠0 && head op≠NOP && ∃i∈{0,1}: hi.wen && (hi.rd==head.rs1 || hi.rd==head.rs2)`.
  - at most 2 consecutive bubbles per head.
- Not defined:
  - no history logic is present; `stall` and `bubble_cnt` are tied to 0;
  - the head pops whenever the queue is non-empty. Forwarding is the pipeline's responsibility.

## Structure
- Shared package `simple_pipe_pkg`:
  - op constants OP_NOP/ADD/SUB/AND;
  - NOP encoding `8'h00`;
  - field-slice functions for op/rs1/rs2/rd;
  - an `is_wen(op)` function.
- The pipeline core imports the same package.
- One sub-module, `simple_pipe_inst_fifo`: DEPTH×8 circular buffer with wrap-around read/write pointers and an occupancy counter, providing push/pop/full/empty/head.
- The issue register, hazard history and counters live in the top.

## Test plan
- Reset: assert `rst` 1 cycle → `out_inst=00`, `in_ready=1`, `q_count=0`, both counters 0. Repeat `rst` while 3 entries are queued → all cleared next cycle.
- Fill with `issue_en=0`: push 0x41,0x46,0x4B,0x50, then offer 0x55 → `in_ready=0` after the 4th push, `q_count=4`, `out_inst` stays 00, 0x55 is accepted only after the first pop.
- Empty issue: `issue_en=1`, no pushes for 5 cycles → `out_inst=00` each cycle, `issued_cnt=0`, `bubble_cnt=0`.
- Hazard, macro defined: queue 0x41 (r1=r0+r0), then 0x55 (r1=r1+r1) → `out_inst` sequence 41,00,00,55, `stall` high for 2 cycles, `bubble_cnt=2`, `issued_cnt=2`.
- Hazard, macro undefined: same stimulus → sequence 41,55 back-to-back, `stall=0`, `bubble_cnt=0`.
- Full with simultaneous pop, then wrap: hold the queue full with `issue_en=1` while `in_valid=1` → `in_ready=0` on that edge, `q_count` goes 4→3, the next push is accepted. With CNT_W=4 and 17 issues → `issued_cnt=1`.

Source files
------------

// File: rtl/simple_pipe_pkg.sv
// rtl/simple_pipe_pkg.sv - shared op encodings, field slices and hazard helpers for the simple pipeline
package simple_pipe_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_AND = 2'b11
    } op_e;

    localparam logic [7:0] NOP_INST = 8'h00;

    // One issued slot as seen by the hazard checker: destination and write-enable.
    typedef struct packed {
        logic [1:0] rd;
        logic       wen;
    } hist_t;

    function automatic logic [1:0] inst_op(input logic [7:0] inst);
        return inst[7:6];
    endfunction

    function automatic logic [1:0] inst_rs1(input logic [7:0] inst);
        return inst[5:4];
    endfunction

    function automatic logic [1:0] inst_rs2(input logic [7:0] inst);
        return inst[3:2];
    endfunction

    function automatic logic [1:0] inst_rd(input logic [7:0] inst);
        return inst[1:0];
    endfunction

    // Every non-NOP op writes rd and reads both rs1 and rs2.
    function automatic logic is_wen(input logic [1:0] op);
        return op != OP_NOP;
    endfunction

    // True when the slot h writes a register that inst reads.
    function automatic logic raw_hit(input hist_t h, input logic [7:0] inst);
        return h.wen && ((h.rd == inst_rs1(inst)) || (h.rd == inst_rs2(inst)));
    endfunction

endpackage

// File: rtl/simple_pipe_issue_q_if.sv
// rtl/simple_pipe_issue_q_if.sv - host push handshake and pipeline issue signals of the issue queue
interface simple_pipe_issue_q_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int QW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_inst;
    logic             issue_en;
    logic [7:0]       out_inst;
    logic             out_start;
    logic [QW-1:0]    q_count;
    logic             stall;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output in_valid, in_inst, issue_en,
        input  in_ready, out_inst, out_start, q_count, stall, issued_cnt, bubble_cnt
    );

    modport slave (
        input  in_valid, in_inst, issue_en,
        output in_ready, out_inst, out_start, q_count, stall, issued_cnt, bubble_cnt
    );

endinterface

// File: rtl/simple_pipe_inst_fifo.sv
// rtl/simple_pipe_inst_fifo.sv - DEPTH x 8 circular instruction buffer with occupancy count
module simple_pipe_inst_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;
    logic            push_ok;
    logic            pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];

    // Storage write; no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/simple_pipe_issue_q.sv
// rtl/simple_pipe_issue_q.sv - instruction issue queue; SIMPLE_PIPE_HAZARD_STALL_EN enables RAW bubble insertion
module simple_pipe_issue_q
    import simple_pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    simple_pipe_issue_q_if.slave bus
);
    localparam int QW = $clog2(DEPTH) + 1;

    logic [7:0]       head;
    logic             full;
    logic             empty;
    logic [QW-1:0]    count;
    logic             push;
    logic             pop;
    logic             stall_w;
    logic [7:0]       out_inst_q;
    logic [CNT_W-1:0] issued_q;

    // A full queue refuses pushes even when the head leaves on the same edge.
    assign push = bus.in_valid && !full;
    assign pop  = bus.issue_en && !empty && !stall_w;

    simple_pipe_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.in_inst),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign bus.in_ready   = !full;
    assign bus.q_count    = count;
    assign bus.out_start  = bus.issue_en;
    assign bus.stall      = stall_w;
    assign bus.out_inst   = out_inst_q;
    assign bus.issued_cnt = issued_q;

    // Issue register: load the head on a clean advance, a NOP otherwise; hold when disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_inst_q <= NOP_INST;
            issued_q   <= '0;
        end else if (bus.issue_en) begin
            if (pop) begin
                out_inst_q <= head;
                issued_q   <= issued_q + CNT_W'(1);
            end else begin
                out_inst_q <= NOP_INST;
            end
        end
    end

`ifdef SIMPLE_PIPE_HAZARD_STALL_EN
    hist_t            h0;
    hist_t            h1;
    logic [CNT_W-1:0] bubble_q;

    // Hold the head while either of the last two issued slots writes one of its sources.
    // Two bubbles flush both slots to wen=0, so a head never waits more than twice.
    always_comb begin
        stall_w = 1'b0;
        if (!empty && is_wen(inst_op(head))) begin
            stall_w = raw_hit(h0, head) || raw_hit(h1, head);
        end
    end

    // History shifts on every advance; bubbles and empty-queue NOPs enter as wen=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            h0       <= '0;
            h1       <= '0;
            bubble_q <= '0;
        end else if (bus.issue_en) begin
            h1 <= h0;
            if (pop) begin
                h0 <= '{rd: inst_rd(head), wen: is_wen(inst_op(head))};
            end else begin
                h0 <= '0;
            end
            if (stall_w) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign bus.bubble_cnt = bubble_q;
`else
    assign stall_w        = 1'b0;
    assign bus.bubble_cnt = '0;
`endif

endmodule
